// File: rtl/bcd_down_timer.sv
// bcd_down_timer: cascaded BCD down counter with prescaler, Load/Start control and a one-cycle Done pulse.
// Define BCD_TIMER_AUTORELOAD_EN to reload the last valid preset on the terminal tick instead of stopping.
module bcd_down_timer #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                CLK,
    input  logic                MR,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] P,
    input  logic                Start,
    input  logic                Enable,
    output logic [4*DIGITS-1:0] Q,
    output logic                Busy,
    output logic                Done,
    output logic                Zero,
    output logic                Err
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [W-1:0]  q_dec;
    logic          p_valid;
    logic          borrow;
`ifdef BCD_TIMER_AUTORELOAD_EN
    logic [W-1:0]  preset;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_dec  = Q;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (Q[4*i +: 4] == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = Q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        p_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (P[4*i +: 4] > 4'd9) p_valid = 1'b0;
        end
    end

    assign Zero = (Q == '0);
    assign Busy = (state == RUN);

    // Done toggles rather than sets so back-to-back completion events never give a two-cycle pulse.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            Q     <= '0;
            state <= IDLE;
            pre   <= '0;
            Done  <= 1'b0;
            Err   <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            preset <= '0;
`endif
        end else begin
            Done <= 1'b0;
            if (Load) begin
                if (p_valid) begin
                    Q   <= P;
                    Err <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
                    preset <= P;
`endif
                end else begin
                    Err <= 1'b1;
                end
                state <= IDLE;
                pre   <= '0;
            end else if (Start && state == IDLE) begin
                if (!Zero) begin
                    state <= RUN;
                    pre   <= '0;
                end else begin
                    Done <= ~Done;
                end
            end else if (state == RUN && Enable) begin
                if (pre == PRE_LAST) begin
                    pre <= '0;
                    if (q_dec == '0) begin
                        Done <= ~Done;
`ifdef BCD_TIMER_AUTORELOAD_EN
                        Q <= preset;
`else
                        Q     <= '0;
                        state <= IDLE;
`endif
                    end else begin
                        Q <= q_dec;
                    end
                end else begin
                    pre <= pre + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: PRESCALE=1 and PRESCALE=3 instances share stimulus and are
// compared every cycle against an integer-arithmetic model, plus directed literal checks.
module tb_bcd_down_timer;

    logic        CLK = 1'b0;
    logic        MR  = 1'b1;
    logic        load = 1'b0, start = 1'b0, enable = 1'b0;
    logic [15:0] p = '0;

    logic [15:0] q1, q3;
    logic        busy1, done1, zero1, err1;
    logic        busy3, done3, zero3, err3;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    bcd_down_timer #(.DIGITS(4), .PRESCALE(1)) u_p1 (
        .CLK(CLK), .MR(MR), .Load(load), .P(p), .Start(start), .Enable(enable),
        .Q(q1), .Busy(busy1), .Done(done1), .Zero(zero1), .Err(err1)
    );

    bcd_down_timer #(.DIGITS(4), .PRESCALE(3)) u_p3 (
        .CLK(CLK), .MR(MR), .Load(load), .P(p), .Start(start), .Enable(enable),
        .Q(q3), .Busy(busy3), .Done(done3), .Zero(zero3), .Err(err3)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int value;
        bit run;
        bit done;
        bit err;
        int pre;
        int preset;
    } mdl_t;

    mdl_t m1, m3;

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] b);
        for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [15:0] b);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    // Next model state for one clock edge, from the timer's rules in plain integer arithmetic.
    function automatic mdl_t mdl_step(input mdl_t m, input bit ld, input logic [15:0] pp,
                                      input bit st, input bit en, input int presc);
        mdl_t n = m;
        bit   ev = 1'b0;
        if (ld) begin
            if (bcd_ok(pp)) begin
                n.value  = bcd2int(pp);
                n.err    = 1'b0;
                n.preset = n.value;
            end else begin
                n.err = 1'b1;
            end
            n.run = 1'b0;
            n.pre = 0;
        end else if (st && !m.run) begin
            if (m.value != 0) begin
                n.run = 1'b1;
                n.pre = 0;
            end else begin
                ev = 1'b1;
            end
        end else if (m.run && en) begin
            if (m.pre + 1 == presc) begin
                n.pre   = 0;
                n.value = m.value - 1;
                if (n.value == 0) begin
                    ev = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
                    n.value = m.preset;
`else
                    n.run = 1'b0;
`endif
                end
            end else begin
                n.pre = m.pre + 1;
            end
        end
        n.done = ev && !m.done;
        return n;
    endfunction

    always @(posedge CLK or posedge MR) begin
        if (MR) begin
            m1 <= '{default: 0};
            m3 <= '{default: 0};
        end else begin
            m1 <= mdl_step(m1, load, p, start, enable, 1);
            m3 <= mdl_step(m3, load, p, start, enable, 3);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp(input string tag, input mdl_t m, input logic [15:0] q,
                       input logic b, input logic d, input logic z, input logic e);
        check({tag, "_q"},    32'(q), 32'(int2bcd(m.value)));
        check({tag, "_busy"}, 32'(b), 32'(m.run));
        check({tag, "_done"}, 32'(d), 32'(m.done));
        check({tag, "_zero"}, 32'(z), 32'(m.value == 0));
        check({tag, "_err"},  32'(e), 32'(m.err));
    endtask

    always @(negedge CLK) begin
        if (cmp_en && !MR) begin
            cmp("p1", m1, q1, busy1, done1, zero1, err1);
            cmp("p3", m3, q3, busy3, done3, zero3, err3);
        end
    end

    // Drive inputs at a falling edge, then return at the next falling edge with the result visible.
    task automatic step(input bit l, input logic [15:0] pv, input bit s, input bit e);
        load = l; p = pv; start = s; enable = e;
        @(negedge CLK);
    endtask

    initial begin
        #2;
        check("rst_q",    32'(q1), 32'h0);
        check("rst_zero", 32'(zero1), 32'h1);
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_done", 32'(done1), 32'h0);
        check("rst_err",  32'(err1), 32'h0);
        @(negedge CLK);
        MR = 1'b0;
        @(negedge CLK);
        cmp_en = 1'b1;

        // Countdown 3 -> 0 with a single-cycle Done.
        step(1'b1, 16'h0003, 1'b0, 1'b1);
        check("t1_load_q", 32'(q1), 32'h0003);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        check("t1_busy", 32'(busy1), 32'h1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t1_q2", 32'(q1), 32'h0002);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t1_q1", 32'(q1), 32'h0001);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t1_q0", 32'(q1), 32'h0000);
        check("t1_done", 32'(done1), 32'h1);
        check("t1_idle", 32'(busy1), 32'h0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t1_done_off", 32'(done1), 32'h0);

        // Borrow ripple.
        step(1'b1, 16'h0100, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t2_0099", 32'(q1), 32'h0099);
        step(1'b1, 16'h1000, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t2_0999", 32'(q1), 32'h0999);
        step(1'b1, 16'h0010, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t2_0009", 32'(q1), 32'h0009);

        // Invalid preset keeps Q and sets Err; a valid one clears it.
        step(1'b1, 16'h0042, 1'b0, 1'b0);
        step(1'b1, 16'h00A5, 1'b0, 1'b0);
        check("t3_hold", 32'(q1), 32'h0042);
        check("t3_err",  32'(err1), 32'h1);
        step(1'b1, 16'h0007, 1'b0, 1'b0);
        check("t3_q7",   32'(q1), 32'h0007);
        check("t3_clr",  32'(err1), 32'h0);

        // Prescaler of 3 with Enable gaps.
        step(1'b1, 16'h0005, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t4_hold", 32'(q3), 32'h0005);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t4_tick", 32'(q3), 32'h0004);

        // Asynchronous reset mid-run.
        step(1'b1, 16'h0057, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t5_run", 32'(busy3), 32'h1);
        #2 MR = 1'b1;
        #1;
        check("t5_q",    32'(q3), 32'h0);
        check("t5_busy", 32'(busy3), 32'h0);
        check("t5_zero", 32'(zero3), 32'h1);
        check("t5_done", 32'(done3), 32'h0);
        load = 1'b0; start = 1'b0; enable = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        MR = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t5_nodone", 32'(done3), 32'h0);

        // Start at zero: Done pulses once, even with Start held.
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t6_done", 32'(done1), 32'h1);
        check("t6_busy", 32'(busy1), 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t6_no2", 32'(done1), 32'h0);

`ifdef BCD_TIMER_AUTORELOAD_EN
        step(1'b1, 16'h0002, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("ar_q1a", 32'(q1), 32'h0001);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("ar_q2a", 32'(q1), 32'h0002);
        check("ar_done", 32'(done1), 32'h1);
        check("ar_busy", 32'(busy1), 32'h1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("ar_q1b", 32'(q1), 32'h0001);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("ar_done2", 32'(done1), 32'h1);
        step(1'b1, 16'h0000, 1'b0, 1'b0);
`endif

        // Randomised traffic, biased toward small presets so completions occur often.
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] pv;
            pv = '0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) pv[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           pv[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 1) == 0) pv[15:4] = '0;
            step($urandom_range(0, 19) == 0, pv, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
